// File: rtl/draw_pkg.sv
// Shared mode codes, arena geometry and player FSM encoding for the draw pipeline.
package draw_pkg;

    localparam logic [2:0] MENU_MODE  = 3'b000;
    localparam logic [2:0] GAME_MODE  = 3'b001;
    localparam logic [2:0] LOSE_MODE  = 3'b010;
    localparam logic [2:0] WIN_MODE   = 3'b011;
    localparam logic [2:0] MULTI_WAIT = 3'b100;

    localparam int ARENA_TOP    = 317;
    localparam int ARENA_BOTTOM = 617;
    localparam int ARENA_LEFT   = 361;
    localparam int ARENA_RIGHT  = 661;
    localparam int ARENA_BORDER = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ALIVE  = 2'd1;
    localparam logic [1:0] INVULN = 2'd2;

    // Saturate a signed candidate coordinate into [lo, hi].
    function automatic logic [11:0] clamp12(input logic signed [12:0] v,
                                            input logic [11:0] lo,
                                            input logic [11:0] hi);
        if (v < $signed({1'b0, lo}))
            return lo;
        else if (v > $signed({1'b0, hi}))
            return hi;
        else
            return v[11:0];
    endfunction

endpackage

// File: rtl/draw_player_ctl.sv
// Player control: frame tick detection, hit/invulnerability FSM and clamped per-frame motion.
module player_ctl
    import draw_pkg::*;
#(
    parameter int TOP_V_LINE    = ARENA_TOP,
    parameter int BOTTOM_V_LINE = ARENA_BOTTOM,
    parameter int LEFT_H_LINE   = ARENA_LEFT,
    parameter int RIGHT_H_LINE  = ARENA_RIGHT,
    parameter int PLAYER_SIZE   = 16,
    parameter int STEP          = 2,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [2:0]  control_state,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        hit,
    output logic [11:0] player_x,
    output logic [11:0] player_y,
    output logic [1:0]  state,
    output logic [7:0]  inv_cnt
);

    localparam logic [11:0] X_C   = 12'((LEFT_H_LINE + RIGHT_H_LINE - PLAYER_SIZE) / 2);
    localparam logic [11:0] Y_C   = 12'((TOP_V_LINE + BOTTOM_V_LINE - PLAYER_SIZE) / 2);
    localparam logic [11:0] X_MIN = 12'(LEFT_H_LINE);
    localparam logic [11:0] X_MAX = 12'(RIGHT_H_LINE - PLAYER_SIZE);
    localparam logic [11:0] Y_MIN = 12'(TOP_V_LINE);
    localparam logic [11:0] Y_MAX = 12'(BOTTOM_V_LINE - PLAYER_SIZE);
    localparam logic signed [12:0] STEP_S   = 13'(STEP);
    localparam logic [7:0]         INV_INIT = 8'(INVULN_FRAMES);

    logic                vblnk_prev;
    logic                tick;
    logic signed [12:0]  dx, dy;
    logic [11:0]         nx, ny;

    assign tick = vblnk_in & ~vblnk_prev;

    always_comb begin
        dx = '0;
        dy = '0;
        if (move_right && !move_left) dx = STEP_S;
        else if (move_left && !move_right) dx = -STEP_S;
        if (move_down && !move_up) dy = STEP_S;
        else if (move_up && !move_down) dy = -STEP_S;
        nx = clamp12($signed({1'b0, player_x}) + dx, X_MIN, X_MAX);
        ny = clamp12($signed({1'b0, player_y}) + dy, Y_MIN, Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            state      <= IDLE;
            player_x   <= X_C;
            player_y   <= Y_C;
            inv_cnt    <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            // Leaving game mode wins over hit and tick.
            if (control_state != GAME_MODE) begin
                state    <= IDLE;
                player_x <= X_C;
                player_y <= Y_C;
                inv_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ALIVE;
                        player_x <= X_C;
                        player_y <= Y_C;
                    end
                    ALIVE: begin
                        if (hit) begin
                            state   <= INVULN;
                            inv_cnt <= INV_INIT;
                        end
                        if (tick) begin
                            player_x <= nx;
                            player_y <= ny;
                        end
                    end
                    INVULN: begin
                        if (tick) begin
                            player_x <= nx;
                            player_y <= ny;
                            if (inv_cnt == 8'd1) begin
                                state   <= ALIVE;
                                inv_cnt <= '0;
                            end else begin
                                inv_cnt <= inv_cnt - 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/draw_player.sv
// Overlays the player square on the background stream; timing passes through one register.
module draw_player
    import draw_pkg::*;
#(
    parameter int          TOP_V_LINE    = ARENA_TOP,
    parameter int          BOTTOM_V_LINE = ARENA_BOTTOM,
    parameter int          LEFT_H_LINE   = ARENA_LEFT,
    parameter int          RIGHT_H_LINE  = ARENA_RIGHT,
    parameter int          PLAYER_SIZE   = 16,
    parameter int          STEP          = 2,
    parameter logic [11:0] PLAYER_COLOR  = 12'h0_f_f,
    parameter int          INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [2:0]  control_state,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        hit,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [11:0] player_x,
    output logic [11:0] player_y,
    output logic        invuln
);

    logic [1:0]  state;
    logic [7:0]  inv_cnt;
    logic        in_sprite;
    logic        show;

    player_ctl #(
        .TOP_V_LINE    (TOP_V_LINE),
        .BOTTOM_V_LINE (BOTTOM_V_LINE),
        .LEFT_H_LINE   (LEFT_H_LINE),
        .RIGHT_H_LINE  (RIGHT_H_LINE),
        .PLAYER_SIZE   (PLAYER_SIZE),
        .STEP          (STEP),
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_ctl (
        .clk           (clk),
        .rst           (rst),
        .vblnk_in      (vblnk_in),
        .control_state (control_state),
        .move_up       (move_up),
        .move_down     (move_down),
        .move_left     (move_left),
        .move_right    (move_right),
        .hit           (hit),
        .player_x      (player_x),
        .player_y      (player_y),
        .state         (state),
        .inv_cnt       (inv_cnt)
    );

    assign invuln = (state == INVULN);

    // Blink during invulnerability: hidden while bit 3 of the frame counter is set.
    always_comb begin
        in_sprite = (hcount_in >= player_x) && (hcount_in < player_x + 12'(PLAYER_SIZE)) &&
                    (vcount_in >= player_y) && (vcount_in < player_y + 12'(PLAYER_SIZE));
        show      = in_sprite && !hblnk_in && !vblnk_in && (state != IDLE) &&
                    ((state == ALIVE) || !inv_cnt[3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= show ? PLAYER_COLOR : rgb_in;
        end
    end

endmodule

// File: tb/tb_draw_player.sv
// Scoreboarded bench for draw_player: reset, latency, motion, clamp, hit blinking, mode exit.
module tb_draw_player;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [2:0]  control_state = 3'b000;
    logic        move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0, hit = 1'b0;
    logic [11:0] hcount_out, vcount_out, rgb_out, player_x, player_y;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out, invuln;

    localparam logic [2:0]  GAME = 3'b001;
    localparam logic [2:0]  MENU = 3'b000;
    localparam logic [11:0] COLOR = 12'h0ff;

    int n_chk = 0;
    int n_fail = 0;

    // Bench model of the sprite position and visibility.
    int   mx = 503, my = 459;
    logic m_vis = 1'b0;

    typedef struct {
        logic [11:0] rgb;
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        hb;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    draw_player dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .control_state(control_state),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .hit(hit),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
        .player_x(player_x), .player_y(player_y), .invuln(invuln)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel through the pipe: expectation pushed at drive, popped one clk later.
    task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic hb, input logic [11:0] rgb);
        exp_t e, got;
        logic ins;
        hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = 1'b0;
        rgb_in = rgb; hsync_in = h[0]; vsync_in = v[0];
        ins = (int'(h) >= mx) && (int'(h) < mx + 16) && (int'(v) >= my) && (int'(v) < my + 16);
        e.rgb = (ins && !hb && m_vis) ? COLOR : rgb;
        e.h = h; e.v = v; e.hs = h[0]; e.hb = hb;
        sb.push_back(e);
        step();
        got = sb.pop_front();
        n_chk++;
        if ({rgb_out, hcount_out, vcount_out, hsync_out, hblnk_out} !==
            {got.rgb, got.h, got.v, got.hs, got.hb}) begin
            n_fail++;
            $display("FAIL pixel (%0d,%0d): rgb=%h h=%0d v=%0d hs=%b hb=%b, want rgb=%h h=%0d v=%0d hs=%b hb=%b",
                     h, v, rgb_out, hcount_out, vcount_out, hsync_out, hblnk_out,
                     got.rgb, got.h, got.v, got.hs, got.hb);
        end
    endtask

    // A minimal frame: one vblnk rising edge, i.e. exactly one tick.
    task automatic frame();
        hblnk_in = 1'b1; vblnk_in = 1'b0;
        step();
        vblnk_in = 1'b1;
        step();
        step();
        vblnk_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hcount_in = 12'd77; vcount_in = 12'd88; rgb_in = 12'habc;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
        step();
        step();
        n_chk++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, invuln} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h inv=%b, want all 0",
                     hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, invuln);
        end
        n_chk++;
        if (player_x !== 12'd503 || player_y !== 12'd459) begin
            n_fail++;
            $display("FAIL reset_pos: x=%0d y=%0d, want 503 459", player_x, player_y);
        end
        rst = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0;
        step();
    endtask

    task automatic test_latency();
        control_state = GAME;
        step();
        m_vis = 1'b1;
        for (int v = 455; v < 478; v++)
            for (int h = 497; h < 524; h++)
                pix(12'(h), 12'(v), 1'b0, 12'($urandom_range(0, 4095)));
        pix(12'd503, 12'd459, 1'b1, 12'h123);
        pix(12'd503, 12'd459, 1'b0, 12'h456);
    endtask

    task automatic test_motion();
        move_right = 1'b1;
        for (int f = 0; f < 200; f++) begin
            frame();
            mx = (mx + 2 > 645) ? 645 : mx + 2;
            n_chk++;
            if (player_x !== 12'(mx) || player_y !== 12'(my)) begin
                n_fail++;
                $display("FAIL move_right frame %0d: x=%0d y=%0d, want %0d %0d", f, player_x, player_y, mx, my);
            end
        end
        move_left = 1'b1;
        for (int f = 0; f < 5; f++) begin
            frame();
            n_chk++;
            if (player_x !== 12'(mx)) begin
                n_fail++;
                $display("FAIL opposing_cancel frame %0d: x=%0d, want %0d", f, player_x, mx);
            end
        end
        move_right = 1'b0;
        move_left = 1'b0;
    endtask

    task automatic test_clamp();
        move_up = 1'b1;
        move_left = 1'b1;
        for (int f = 0; f < 200; f++) begin
            frame();
            mx = (mx - 2 < 361) ? 361 : mx - 2;
            my = (my - 2 < 317) ? 317 : my - 2;
            n_chk++;
            if (player_x !== 12'(mx) || player_y !== 12'(my)) begin
                n_fail++;
                $display("FAIL clamp frame %0d: x=%0d y=%0d, want %0d %0d", f, player_x, player_y, mx, my);
            end
        end
        move_up = 1'b0;
        move_left = 1'b0;
        pix(12'd361, 12'd317, 1'b0, 12'h000);
    endtask

    task automatic test_hit();
        int cnt;
        hit = 1'b1;
        step();
        hit = 1'b0;
        cnt = 60;
        n_chk++;
        if (invuln !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_enter: invuln=%b, want 1", invuln);
        end
        for (int f = 0; f < 60; f++) begin
            m_vis = ((cnt & 8) == 0);
            pix(12'(mx + 3), 12'(my + 3), 1'b0, 12'h5a5);
            if (f == 10) begin
                hit = 1'b1;
                step();
                hit = 1'b0;
            end
            frame();
            cnt = (cnt == 1) ? 0 : cnt - 1;
            n_chk++;
            if (invuln !== (cnt != 0)) begin
                n_fail++;
                $display("FAIL invuln_len tick %0d: invuln=%b, want %b", f + 1, invuln, cnt != 0);
            end
        end
        m_vis = 1'b1;
        pix(12'(mx + 3), 12'(my + 3), 1'b0, 12'h5a5);
    endtask

    task automatic test_mode_exit();
        hit = 1'b1;
        step();
        hit = 1'b0;
        frame();
        frame();
        control_state = MENU;
        step();
        mx = 503; my = 459; m_vis = 1'b0;
        n_chk++;
        if (invuln !== 1'b0 || player_x !== 12'd503 || player_y !== 12'd459) begin
            n_fail++;
            $display("FAIL mode_exit: invuln=%b x=%0d y=%0d, want 0 503 459", invuln, player_x, player_y);
        end
        pix(12'd505, 12'd460, 1'b0, 12'h321);
        control_state = GAME;
        step();
        m_vis = 1'b1;
        n_chk++;
        if (invuln !== 1'b0 || player_x !== 12'd503 || player_y !== 12'd459) begin
            n_fail++;
            $display("FAIL reenter: invuln=%b x=%0d y=%0d, want 0 503 459", invuln, player_x, player_y);
        end
        pix(12'd503, 12'd459, 1'b0, 12'h321);
        pix(12'd519, 12'd459, 1'b0, 12'h777);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_motion();
        test_clamp();
        test_hit();
        test_mode_exit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
